dcache_ctrl: RTL and testbench

// - Sequencing controller for the data-side direct-mapped write-through cache: owns tag/valid/data arrays,

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_array.sv | 61 ++++++
 rtl/dcache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: access modes, FSM states,
// and the byte-lane helpers used by the store path.
package dcache_pkg;

  localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
  localparam logic [2:0] DATA_ADDR_MODE_H  = 3'b001;
  localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
  localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;
  localparam logic [2:0] DATA_ADDR_MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } dcache_state_t;

  function automatic logic [3:0] strobe(input logic [2:0] mode, input logic [1:0] offset);
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: strobe = 4'b0001 << offset;
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: strobe = 4'b0011 << {offset[1], 1'b0};
      default:                             strobe = 4'hF;
    endcase
  endfunction

  // Right-aligned store data copied into every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] replicate(input logic [2:0] mode, input logic [31:0] wdata);
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: replicate = {4{wdata[7:0]}};
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: replicate = {2{wdata[15:0]}};
      default:                             replicate = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage: combinational lookup port, byte-strobed
// write port, and a single-cycle invalidate-all.
module dcache_array #(
  parameter int INDEX_W    = 3,
  parameter int TAG_W      = 27,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [INDEX_W-1:0]      rd_index,
  input  logic [TAG_W-1:0]        rd_tag,
  output logic                    rd_hit,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic [INDEX_W-1:0]      wr_index,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data
);
  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS];

  assign rd_hit  = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data = data_mem[rd_index];

  // A flush landing on the same edge as a fill leaves the line invalid.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: tag/data storage is deliberately not reset; the valid bits alone decide
  // whether a line means anything, and resetting RAM would block memory inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wr_strb[b]) begin
          data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through direct-mapped data-cache controller: hit/miss detection, pipeline
// stall, refill and write-through handshakes to data memory, hit/miss statistics.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_addr_mode,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  cache_flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 2;

  dcache_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            strb_q, strb_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  refill_done_q, refill_done_d;
  logic                  store_done_q, store_done_d;
  logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

  logic [INDEX_W-1:0]    cpu_index, arr_index;
  logic [TAG_W-1:0]      cpu_tag, arr_tag;
  logic                  hit, arr_we, flush_now;
  logic [DATA_WIDTH-1:0] line_data, arr_data, cpu_wdata_rep;
  logic [3:0]            arr_strb, cpu_strb;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign cpu_index     = cpu_addr[INDEX_W+1:2];
  assign cpu_tag       = cpu_addr[ADDR_WIDTH-1:INDEX_W+2];
  assign cpu_strb      = strobe(cpu_addr_mode, cpu_addr[1:0]);
  assign cpu_wdata_rep = replicate(cpu_addr_mode, cpu_wdata);

  dcache_array #(
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_now),
    .rd_index(cpu_index),
    .rd_tag  (cpu_tag),
    .rd_hit  (hit),
    .rd_data (line_data),
    .wr_en   (arr_we),
    .wr_index(arr_index),
    .wr_tag  (arr_tag),
    .wr_strb (arr_strb),
    .wr_data (arr_data)
  );

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    strb_d          = strb_q;
    flush_pending_d = flush_pending_q;
    refill_done_d   = refill_done_q;
    store_done_d    = store_done_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    arr_we          = 1'b0;
    arr_index       = cpu_index;
    arr_tag         = cpu_tag;
    arr_strb        = cpu_strb;
    arr_data        = cpu_wdata_rep;
    flush_now       = 1'b0;
    cpu_stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_pending_q) begin
          flush_now       = 1'b1;
          flush_pending_d = 1'b0;
          cpu_stall       = 1'b1;
        end else if (cpu_req) begin
          refill_done_d = 1'b0;
          store_done_d  = 1'b0;
          if (!cpu_we) begin
            if (hit) begin
              // The re-presented load after a refill was already counted as a miss.
              if (!refill_done_q) hit_count_d = sat_inc(hit_count_q);
            end else begin
              cpu_stall    = 1'b1;
              miss_count_d = sat_inc(miss_count_q);
              addr_d       = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
              strb_d       = 4'h0;
              state_d      = RD_REQ;
            end
          end else if (!store_done_q) begin
            // The store already wrote memory once the flag is set; that cycle just retires it.
            cpu_stall = 1'b1;
            if (hit) hit_count_d = sat_inc(hit_count_q);
            arr_we  = hit || (cpu_addr_mode == DATA_ADDR_MODE_W);
            addr_d  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = cpu_wdata_rep;
            strb_d  = cpu_strb;
            state_d = WR_REQ;
          end
        end else if (cache_flush) begin
          flush_now = 1'b1;
        end
      end
      RD_REQ: begin
        cpu_stall = 1'b1;
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cpu_stall = 1'b1;
        if (mem_rvalid) begin
          arr_we        = 1'b1;
          arr_index     = addr_q[INDEX_W+1:2];
          arr_tag       = addr_q[ADDR_WIDTH-1:INDEX_W+2];
          arr_strb      = 4'hF;
          arr_data      = mem_rdata;
          refill_done_d = 1'b1;
          state_d       = IDLE;
        end
      end
      WR_REQ: begin
        cpu_stall = 1'b1;
        if (mem_ready) begin
          store_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cache_flush && !flush_now) flush_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      strb_q          <= '0;
      flush_pending_q <= 1'b0;
      refill_done_q   <= 1'b0;
      store_done_q    <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      strb_q          <= strb_d;
      flush_pending_q <= flush_pending_d;
      refill_done_q   <= refill_done_d;
      store_done_q    <= store_done_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  assign mem_req    = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we     = (state_q == WR_REQ);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = strb_q;
  assign cpu_rdata  = hit ? line_data : '0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic, scored against a
// word-level memory image and a valid/tag table of the cache.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cache_flush;
  logic [2:0]  cpu_addr_mode;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr_mode(cpu_addr_mode),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cache_flush  (cache_flush),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: backing memory by word address, and which lines the cache holds.
  logic [31:0] mem_model [logic [31:0]];
  bit          m_valid [8];
  logic [26:0] m_tag   [8];
  int          m_hits, m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem_model.exists(wa)) return mem_model[wa];
    return (wa * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic int size_of(input logic [2:0] mode);
    if (mode == 3'b000 || mode == 3'b100) return 1;
    if (mode == 3'b001 || mode == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] mode, input logic [1:0] off);
    int n, lane;
    n    = size_of(mode);
    lane = (n == 1) ? int'(off) : (n == 2) ? (off[1] ? 2 : 0) : 0;
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] mode, input logic [31:0] wd);
    int n;
    n = size_of(mode);
    if (n == 1) return {4{wd[7:0]}};
    if (n == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
  endtask

  // One CPU access, held until the stall drops, with the bench acting as data memory.
  task automatic access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                        input bit flush_mid);
    int          idx = int'(addr[4:2]);
    logic [26:0] tg = addr[31:5];
    bit          hit0 = m_valid[idx] && (m_tag[idx] == tg);
    logic [3:0]  es = exp_strb(mode, addr[1:0]);
    logic [31:0] ewd = exp_wdata(mode, wd);
    int exp_stall, exp_txn, stalls, n_txn, wait_rdy, rv_cnt;
    bit flush_arm, timed_out;

    if (!we) begin
      if (hit0) begin
        exp_stall = 0; exp_txn = 0; m_hits++;
      end else if (flush_mid) begin
        exp_stall = 2 * (2 + rdy_dly + rv_dly) + 1; exp_txn = 2; m_misses += 2;
        clear_model();
      end else begin
        exp_stall = 2 + rdy_dly + rv_dly; exp_txn = 1; m_misses++;
      end
      if (!hit0) begin
        m_valid[idx] = 1; m_tag[idx] = tg;
      end
    end else begin
      exp_stall = 2 + rdy_dly; exp_txn = 1;
      if (hit0) m_hits++;
      else if (size_of(mode) == 4) begin
        m_valid[idx] = 1; m_tag[idx] = tg;
      end
    end

    stalls = 0; n_txn = 0; wait_rdy = rdy_dly; rv_cnt = -1; flush_arm = 0; timed_out = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr_mode = mode; cpu_addr = addr; cpu_wdata = wd;
    forever begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; cache_flush = 1'b0;
      if (flush_arm) begin
        cache_flush = 1'b1; flush_arm = 0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = mem_rd(addr); rv_cnt = -1;
        end
      end
      if (mem_req) begin
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_we", 32'(mem_we), 32'(we));
        if (we) begin
          check("mem_wstrb", 32'(mem_wstrb), 32'(es));
          check("mem_wdata", mem_wdata, ewd);
        end
        if (wait_rdy == 0) begin
          mem_ready = 1'b1; n_txn++; wait_rdy = rdy_dly;
          if (we) begin
            logic [31:0] w;
            w = mem_rd(addr);
            for (int b = 0; b < 4; b++) if (es[b]) w[8*b +: 8] = ewd[8*b +: 8];
            mem_model[{addr[31:2], 2'b00}] = w;
          end else begin
            rv_cnt = rv_dly;
            if (flush_mid && n_txn == 1) flush_arm = 1;
          end
        end else begin
          wait_rdy--;
        end
      end
      #1;
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 200) begin
        timed_out = 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("stall_timeout", 32'(timed_out), 32'd0);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("mem_txns", 32'(n_txn), 32'(exp_txn));
    if (!we) check("cpu_rdata", cpu_rdata, mem_rd(addr));
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; cache_flush = 1'b0;
    #1;
    check("hit_count", 32'(hit_count), 32'(m_hits));
    check("miss_count", 32'(miss_count), 32'(m_misses));
  endtask

  task automatic idle_flush();
    cache_flush = 1'b1;
    #1;
    check("flush_idle_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cache_flush = 1'b0;
    clear_model();
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr_mode = 3'b010; cpu_addr = '0;
    cpu_wdata = '0; cache_flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    m_hits = 0; m_misses = 0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);

    // Cold load: one miss cycle, one request cycle, two waiting cycles.
    mem_model[32'h100] = 32'hDEADBEEF;
    access(1'b0, 3'b010, 32'h100, '0, 0, 2, 0);
    check("cold_miss_count", 32'(miss_count), 32'd1);
    access(1'b0, 3'b010, 32'h100, '0, 0, 1, 0);
    check("warm_hit_count", 32'(hit_count), 32'd1);

    access(1'b1, 3'b010, 32'h104, 32'h11223344, 3, 1, 0);
    access(1'b0, 3'b010, 32'h104, '0, 0, 1, 0);
    check("sw_readback", mem_rd(32'h104), 32'h11223344);

    access(1'b1, 3'b010, 32'h100, 32'h0, 0, 1, 0);
    access(1'b1, 3'b000, 32'h102, 32'h000000AA, 1, 1, 0);
    access(1'b0, 3'b010, 32'h100, '0, 0, 1, 0);
    check("sb_merge", mem_rd(32'h100), 32'h00AA0000);
    check("sh_strb", 32'(exp_strb(3'b001, 2'b11)), 32'hC);
    access(1'b1, 3'b001, 32'h203, 32'h0000BEEF, 0, 1, 0);
    access(1'b0, 3'b010, 32'h200, '0, 0, 1, 0);

    // Conflicts on index 0.
    access(1'b0, 3'b010, 32'h100, '0, 1, 1, 0);
    access(1'b0, 3'b010, 32'h120, '0, 0, 3, 0);
    access(1'b0, 3'b010, 32'h100, '0, 2, 2, 0);

    // Flush raised while the refill is outstanding.
    access(1'b0, 3'b010, 32'h184, '0, 0, 3, 1);
    access(1'b0, 3'b010, 32'h100, '0, 0, 1, 0);
    idle_flush();
    access(1'b0, 3'b010, 32'h100, '0, 0, 1, 0);

    // Reset while the refill request is waiting on memory.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h144; cpu_addr_mode = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_stall", 32'(cpu_stall), 32'd0);
    check("midrst_hits", 32'(hit_count), 32'd0);
    check("midrst_misses", 32'(miss_count), 32'd0);
    clear_model();
    m_hits = 0; m_misses = 0;
    access(1'b0, 3'b010, 32'h100, '0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [2:0]  mode;
      int          sel;
      bit          we;
      a    = 32'h1000 | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      sel  = $urandom_range(0, 4);
      mode = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 :
             (sel == 3) ? 3'b100 : 3'b101;
      we   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) idle_flush();
      access(we, mode, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
             !we && ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
